// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI master shift engine:
//   - spi_state_e     : engine state (IDLE / SETUP / SHIFT / HOLD)
//   - SPI_MODE0..3    : {cpol, cpha} encodings of the four SPI modes
//   - SPI_W_DEFAULT   : default transfer word width
//   - SPI_DIV_W_DEFAULT : default width of the clock-divider field
// -----------------------------------------------------------------------------
package spi_pkg;

    localparam int unsigned SPI_W_DEFAULT     = 32;
    localparam int unsigned SPI_DIV_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHIFT = 2'd2,
        ST_HOLD  = 2'd3
    } spi_state_e;

    // {cpol, cpha}
    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

endpackage : spi_pkg

// File: rtl/spi_clkgen.sv
// -----------------------------------------------------------------------------
// spi_clkgen
// Half-period timer and SCLK generator for spi_xfer_engine.
// The down-counter paces every non-idle phase (SETUP, each SCLK half period,
// HOLD); SCLK toggles and the edge counter advances only while shifting.
//
// Ports:
//   clk, rst          : system clock, asynchronous active-high reset
//   start_i           : accepted start; latches clk_div_i, clears edge count
//   busy_i            : engine is not idle
//   shift_i           : engine is in the SHIFT phase
//   clk_div_i [DIV_W] : half-period minus 1 (live input, latched on start)
//   cpol_i            : SCLK idle level, followed while idle
//   tick_o            : current phase interval expires this cycle
//   lead_edge_o       : a leading SCLK edge is issued this cycle
//   trail_edge_o      : a trailing SCLK edge is issued this cycle
//   last_edge_o       : edge counter sits at the final edge (2W-1)
//   sclk_o            : registered serial clock
// -----------------------------------------------------------------------------
module spi_clkgen
    import spi_pkg::*;
#(
    parameter int unsigned W     = SPI_W_DEFAULT,
    parameter int unsigned DIV_W = SPI_DIV_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             busy_i,
    input  logic             shift_i,
    input  logic [DIV_W-1:0] clk_div_i,
    input  logic             cpol_i,
    output logic             tick_o,
    output logic             lead_edge_o,
    output logic             trail_edge_o,
    output logic             last_edge_o,
    output logic             sclk_o
);

    localparam int unsigned     EW        = $clog2(2 * W);
    localparam logic [EW-1:0]   LAST_EDGE = EW'(2 * W - 1);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [EW-1:0]    edge_q, edge_d;
    logic             sclk_q, sclk_d;
    logic             tick;
    logic             last_edge;

    assign tick      = busy_i && (cnt_q == '0);
    assign last_edge = (edge_q == LAST_EDGE);

    // NOTE: every variable gets a default at the top of always_comb so no
    // path leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        cnt_d  = cnt_q;
        edge_d = edge_q;
        sclk_d = sclk_q;
        if (!busy_i) begin
            // While idle the counter tracks the live divider so the first
            // SETUP cycle already holds the value latched with start.
            cnt_d  = clk_div_i;
            sclk_d = cpol_i;
        end else if (tick) begin
            // Count down to zero and reload: clk_div = all-ones never wraps.
            cnt_d = div_q;
            if (shift_i) begin
                sclk_d = ~sclk_q;
                if (!last_edge) begin
                    edge_d = edge_q + EW'(1);
                end
            end
        end else begin
            cnt_d = cnt_q - DIV_W'(1);
        end
        if (start_i) begin
            edge_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of its peers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q  <= '0;
            cnt_q  <= '0;
            edge_q <= '0;
            sclk_q <= 1'b0;
        end else begin
            if (start_i) begin
                div_q <= clk_div_i;
            end
            cnt_q  <= cnt_d;
            edge_q <= edge_d;
            sclk_q <= sclk_d;
        end
    end

    assign tick_o       = tick;
    assign lead_edge_o  = tick && shift_i && !edge_q[0];
    assign trail_edge_o = tick && shift_i &&  edge_q[0];
    assign last_edge_o  = last_edge;
    assign sclk_o       = sclk_q;

endmodule : spi_clkgen

// File: rtl/spi_xfer_engine.sv
// -----------------------------------------------------------------------------
// spi_xfer_engine
// Full-duplex SPI master shift engine. Accepts one word with a start pulse,
// shifts it out MSB first on spi_mosi while sampling spi_miso, and returns the
// received word with a one-cycle rx_valid pulse. SCLK timing and CPOL/CPHA
// handling come from spi_clkgen; this level holds the FSM and shift registers.
//
// Ports:
//   clk, rst        : system clock, asynchronous active-high reset
//   start           : transfer request, taken only while ready = 1
//   tx_data [W]     : word to send (latched on accepted start)
//   clk_div [DIV_W] : SCLK half-period minus 1 in clk cycles (latched)
//   cpol, cpha      : SPI mode (latched)
//   ready           : idle, can accept start
//   rx_data [W]     : last received word, held until the next completion
//   rx_valid        : one-cycle pulse when rx_data updates
//   spi_sclk, spi_mosi, spi_cs_n : serial outputs (all registered)
//   spi_miso        : serial input
// -----------------------------------------------------------------------------
module spi_xfer_engine
    import spi_pkg::*;
#(
    parameter int unsigned W     = SPI_W_DEFAULT,
    parameter int unsigned DIV_W = SPI_DIV_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [W-1:0]     tx_data,
    input  logic [DIV_W-1:0] clk_div,
    input  logic             cpol,
    input  logic             cpha,
    output logic             ready,
    output logic [W-1:0]     rx_data,
    output logic             rx_valid,
    output logic             spi_sclk,
    output logic             spi_mosi,
    input  logic             spi_miso,
    output logic             spi_cs_n
);

    spi_state_e   state_q, state_d;
    logic [W-1:0] tx_sr_q, tx_sr_d;
    logic [W-1:0] rx_sr_q, rx_sr_d;
    logic [W-1:0] rx_data_q, rx_data_d;
    logic         rx_valid_q, rx_valid_d;
    logic         ready_q, ready_d;
    logic         cs_n_q, cs_n_d;
    logic         mosi_q, mosi_d;
    logic         cpha_q, cpha_d;

    logic accept;
    logic tick, lead_edge, trail_edge, last_edge;

    assign accept = start && (state_q == ST_IDLE);

    spi_clkgen #(
        .W     (W),
        .DIV_W (DIV_W)
    ) u_clkgen (
        .clk          (clk),
        .rst          (rst),
        .start_i      (accept),
        .busy_i       (state_q != ST_IDLE),
        .shift_i      (state_q == ST_SHIFT),
        .clk_div_i    (clk_div),
        .cpol_i       (cpol),
        .tick_o       (tick),
        .lead_edge_o  (lead_edge),
        .trail_edge_o (trail_edge),
        .last_edge_o  (last_edge),
        .sclk_o       (spi_sclk)
    );

    always_comb begin
        state_d    = state_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        mosi_d     = mosi_q;
        cpha_d     = cpha_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    tx_sr_d = tx_data;
                    rx_sr_d = '0;
                    cpha_d  = cpha;
                    // CPHA=0 presents the MSB before the first SCLK edge.
                    if (!cpha) begin
                        mosi_d = tx_data[W-1];
                    end
                    state_d = ST_SETUP;
                end
            end

            ST_SETUP: begin
                if (tick) begin
                    state_d = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                if (lead_edge) begin
                    if (cpha_q) begin
                        mosi_d  = tx_sr_q[W-1];
                        tx_sr_d = {tx_sr_q[W-2:0], 1'b0};
                    end else begin
                        rx_sr_d = {rx_sr_q[W-2:0], spi_miso};
                    end
                end
                if (trail_edge) begin
                    if (cpha_q) begin
                        rx_sr_d = {rx_sr_q[W-2:0], spi_miso};
                    end else if (!last_edge) begin
                        // MSB already went out in SETUP; bit W-2 is next.
                        mosi_d  = tx_sr_q[W-2];
                        tx_sr_d = {tx_sr_q[W-2:0], 1'b0};
                    end
                end
                if (tick && last_edge) begin
                    state_d = ST_HOLD;
                end
            end

            ST_HOLD: begin
                if (tick) begin
                    rx_data_d  = rx_sr_q;
                    rx_valid_d = 1'b1;
                    state_d    = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        // Status outputs are registered copies of the next state.
        cs_n_d  = (state_d == ST_IDLE);
        ready_d = (state_d == ST_IDLE);
    end

    // NOTE: shift registers are reset along with the FSM so a transfer cut
    // short by reset can never leak stale bits into a later rx_data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            ready_q    <= 1'b1;
            cs_n_q     <= 1'b1;
            mosi_q     <= 1'b0;
            cpha_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            ready_q    <= ready_d;
            cs_n_q     <= cs_n_d;
            mosi_q     <= mosi_d;
            cpha_q     <= cpha_d;
        end
    end

    assign ready    = ready_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign spi_mosi = mosi_q;
    assign spi_cs_n = cs_n_q;

endmodule : spi_xfer_engine
